// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA raster timing constants.
// Holds the default 640x480@60 timing, the derived line/frame totals and the
// counter width used by the sync generator, colour generator and game logic.
package vga_timing_pkg;

    localparam int CLK_DIV   = 2;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W     = 10;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bus from the sync generator to its consumers.
//   pix_en     one-clock pulse per pixel advance
//   h_count    horizontal position
//   v_count    vertical position
//   bright     active-video qualifier for (h_count, v_count)
//   hsync      active-low horizontal sync
//   vsync      active-low vertical sync
//   frame_tick one-clock pulse at the start of vertical blank
// master: the timing generator; slave: colour generator / game logic.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic pix_en;
    cnt_t h_count;
    cnt_t v_count;
    logic bright;
    logic hsync;
    logic vsync;
    logic frame_tick;

    modport master (
        output pix_en, h_count, v_count, bright, hsync, vsync, frame_tick
    );

    modport slave (
        input pix_en, h_count, v_count, bright, hsync, vsync, frame_tick
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: next-state logic for one raster axis (purely combinational).
//   advance    step the count this clock
//   count      current registered count
//   count_next value the count takes on the coming edge
//   wrap       advance while at TOTAL-1 (count_next returns to 0)
//   active     count_next lies in the visible region
//   sync_n     active-low sync for count_next
// The caller owns the registers; all outputs describe the next value so the
// qualifiers can be registered alongside the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE,
    parameter int FRONT   = H_FRONT,
    parameter int SYNC    = H_SYNC,
    parameter int BACK    = H_BACK
) (
    input  logic advance,
    input  cnt_t count,
    output cnt_t count_next,
    output logic wrap,
    output logic active,
    output logic sync_n
);

    localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_START = VISIBLE + FRONT;
    localparam int SYNC_END   = SYNC_START + SYNC;

    logic at_end;

    assign at_end = (count == cnt_t'(TOTAL - 1));
    assign wrap   = advance && at_end;

    always_comb begin
        count_next = count;
        if (advance) begin
            count_next = at_end ? '0 : count + cnt_t'(1);
        end
    end

    assign active = (count_next < cnt_t'(VISIBLE));
    assign sync_n = !((count_next >= cnt_t'(SYNC_START)) &&
                      (count_next <  cnt_t'(SYNC_END)));

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   vga    master side of vga_sync_gen_if (pix_en, h_count, v_count, bright,
//          hsync, vsync, frame_tick), all outputs registered
// A clock divider produces pix_en; the horizontal and vertical counters step
// on the edge that ends a pix_en cycle. Qualifiers are registered from the
// next counter values, so they always match the counts shown with them.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic           clock,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_next;
    logic             pix_en_q;
    cnt_t             h_q;
    cnt_t             v_q;
    logic             bright_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             tick_q;

    cnt_t             h_next;
    cnt_t             v_next;
    logic             h_wrap;
    logic             h_active;
    logic             v_active;
    logic             h_sync_n;
    logic             v_sync_n;

    assign div_next = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .advance    (pix_en_q),
        .count      (h_q),
        .count_next (h_next),
        .wrap       (h_wrap),
        .active     (h_active),
        .sync_n     (h_sync_n)
    );

    // h_wrap already includes pix_en, so it is the full vertical advance.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .advance    (h_wrap),
        .count      (v_q),
        .count_next (v_next),
        .wrap       (),
        .active     (v_active),
        .sync_n     (v_sync_n)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            bright_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_next;
            // Registered from the next divider value so pix_en is high
            // exactly while the divider sits at CLK_DIV-1.
            pix_en_q <= (div_next == DIV_LAST);
            h_q      <= h_next;
            v_q      <= v_next;
            // Qualifiers only move with the counters; this keeps the first
            // post-reset pixel dark until the first real advance.
            if (pix_en_q) begin
                bright_q <= h_active && v_active;
                hsync_q  <= h_sync_n;
                vsync_q  <= v_sync_n;
            end
            tick_q   <= h_wrap && (v_next == cnt_t'(V_VISIBLE));
        end
    end

    assign vga.pix_en     = pix_en_q;
    assign vga.h_count    = h_q;
    assign vga.v_count    = v_q;
    assign vga.bright     = bright_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two instances (default 640x480 with CLK_DIV=2, and a tiny
// raster with CLK_DIV=1) share one reset that is pulsed at random moments
// between clock edges. Expected outputs come from a closed-form model of the
// number of clocks since reset release.
module tb_vga_sync_gen;

    typedef struct {
        bit pix_en;
        int h;
        int v;
        bit bright;
        bit hsync;
        bit vsync;
        bit tick;
    } exp_t;

    logic clock;
    logic reset;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen dut_a (
        .clock (clock),
        .reset (reset),
        .vga   (bus_a)
    );

    vga_sync_gen #(
        .CLK_DIV   (1),
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (1),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .vga   (bus_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 0;
    int   k_now = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // State after k clock edges since reset release (k=0: release cycle or
    // still in reset). Pixel advances happen on edges that end a pix_en cycle.
    function automatic exp_t model(int d, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb, int k);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int p;
        bit prev_en;
        e.pix_en = (k > 0) && ((k % d) == d - 1);
        if (d == 1) p = (k > 0) ? k - 1 : 0;
        else        p = k / d;
        e.h      = p % ht;
        e.v      = (p / ht) % vt;
        e.bright = (p > 0) && (e.h < hv) && (e.v < vv);
        e.hsync  = !((e.h >= hv + hf) && (e.h < hv + hf + hs));
        e.vsync  = !((e.v >= vv + vf) && (e.v < vv + vf + vs));
        prev_en  = (k > 1) && (((k - 1) % d) == d - 1);
        e.tick   = prev_en && (e.h == 0) && (e.v == vv);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)",
                     nm, act, expv, k_now, $time);
        end
    endtask

    // Stimulus: random reset pulses, applied at a random point between edges.
    initial begin
        int k;
        int rst_left;
        int dly;
        reset    = 1'b0;
        k        = 0;
        rst_left = 3;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(posedge clock);
            dly = $urandom_range(1, 4);
            #dly;
            if (rst_left > 0) begin
                reset = 1'b0;
                rst_left--;
                k = 0;
            end else if (!reset) begin
                reset = 1'b1;
                k = 0;
            end else begin
                k++;
                if ($urandom_range(0, 2999) == 0) begin
                    reset    = 1'b0;
                    k        = 0;
                    rst_left = $urandom_range(0, 3);
                end
            end
            k_now = k;
            q_a.push_back(model(2, 640, 16, 96, 48, 480, 10, 2, 33, k));
            q_b.push_back(model(1, 8, 2, 3, 1, 4, 1, 1, 1, k));
        end
        @(negedge clock);
        #1;
        stim_done = 1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0",
                     q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: pops one expectation per DUT each cycle, away from the edge.
    initial begin
        exp_t ea;
        exp_t eb;
        int   cyc = 0;
        int   last_tick = -1;
        int   hs_run = -1;
        forever begin
            @(negedge clock);
            if (!stim_done) begin
                cyc++;
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL queue: empty at cycle %0d, expected an entry", cyc);
                end else begin
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    chk("a.pix_en",  32'(bus_a.pix_en),     32'(ea.pix_en));
                    chk("a.h_count", 32'(bus_a.h_count),    32'(ea.h));
                    chk("a.v_count", 32'(bus_a.v_count),    32'(ea.v));
                    chk("a.bright",  32'(bus_a.bright),     32'(ea.bright));
                    chk("a.hsync",   32'(bus_a.hsync),      32'(ea.hsync));
                    chk("a.vsync",   32'(bus_a.vsync),      32'(ea.vsync));
                    chk("a.tick",    32'(bus_a.frame_tick), 32'(ea.tick));
                    chk("b.pix_en",  32'(bus_b.pix_en),     32'(eb.pix_en));
                    chk("b.h_count", 32'(bus_b.h_count),    32'(eb.h));
                    chk("b.v_count", 32'(bus_b.v_count),    32'(eb.v));
                    chk("b.bright",  32'(bus_b.bright),     32'(eb.bright));
                    chk("b.hsync",   32'(bus_b.hsync),      32'(eb.hsync));
                    chk("b.vsync",   32'(bus_b.vsync),      32'(eb.vsync));
                    chk("b.tick",    32'(bus_b.frame_tick), 32'(eb.tick));
                end
                // Period/width checks independent of the per-cycle model.
                if (!reset) begin
                    last_tick = -1;
                    hs_run    = -1;
                end else begin
                    if (bus_b.frame_tick) begin
                        if (last_tick >= 0) chk("b.tick_period", 32'(cyc - last_tick), 32'd98);
                        last_tick = cyc;
                    end
                    if (!bus_a.hsync) begin
                        if (hs_run >= 0) hs_run++;
                    end else begin
                        if (hs_run > 0) chk("a.hsync_width", 32'(hs_run), 32'd192);
                        hs_run = 0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates VGA raster timing: horizontal and vertical pixel counters, active-low hsync/vsync, and the `bright` (active video) qualifier.
It is the producer of the `h_count`/`v_count`/`bright` bus consumed by the pixel colour generator.
It also emits a once-per-frame tick at the start of vertical blanking, so game-state logic (bird, pipe and hole positions) updates off-screen.
The default timing is 640x480@60, with a pixel enable derived from the system clock by an integer divider.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 1 means every cycle is a pixel.
H_VISIBLE, 640, active pixels per line.
H_FRONT, 16, horizontal front porch in pixels.
H_SYNC, 96, hsync pulse width in pixels.
H_BACK, 48, horizontal back porch in pixels.
V_VISIBLE, 480, active lines per frame.
V_FRONT, 10, vertical front porch in lines.
V_SYNC, 2, vsync pulse width in lines.
V_BACK, 33, vertical back porch in lines.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
pix_en  output  1  one-clock pulse marking each pixel advance.
h_count  output  10  horizontal position, 0..H_TOTAL-1.
v_count  output  10  vertical position, 0..V_TOTAL-1.
bright  output  1  high while (h_count,v_count) is inside the active area.
hsync  output  1  active-low horizontal sync.
vsync  output  1  active-low vertical sync.
frame_tick  output  1  one-clock pulse at the start of vertical blank.

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525). Both must be <= 1024.
- Reset (reset low, asynchronous, takes effect immediately):
  - divider, h_count and v_count = 0
  - pix_en = 0, bright = 0, frame_tick = 0
  - hsync = 1, vsync = 1
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en is high during the clock in which the divider equals CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly high after reset.
- Counters advance only on the clock edge that ends a pix_en cycle:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps to 0 at V_TOTAL-1 when h_count wraps.
  - Simultaneous wrap: (H_TOTAL-1, V_TOTAL-1) goes to (0,0) on one edge.
- Registered qualifiers: bright, hsync and vsync are computed from the next counter values and registered on the same edge. They are therefore always consistent with the h_count/v_count presented in the same cycle. Zero combinational output paths.
  - bright = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Post-reset first pixel: since bright resets to 0, pixel (0,0) of the first frame after reset is dark. This is accepted. From the first pixel advance onward the invariant holds.
- frame_tick:
  - Registered, high for exactly one clock.
  - Asserted in the cycle where the counters first present (h=0, v=V_VISIBLE).
  - Exactly one pulse per V_TOTAL*H_TOTAL*CLK_DIV clocks.
- Latency:
  - Counters change on the clock after a pix_en-high cycle.
  - The downstream colour generator adds one further register stage; that is the consumer's concern.
- No input stalls; the block free-runs whenever reset is high.

Decomposition:
- Shared package vga_timing_pkg:
  - default 640x480 timing constants (the H_*/V_* values and CLK_DIV)
  - derived H_TOTAL/V_TOTAL
  - the counter width localparam (10), reused by the colour generator and game logic.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters VISIBLE/FRONT/SYNC/BACK
  - inputs: advance enable, count
  - outputs: count, wrap, active, sync_n (the next-value versions used for registering).
- The vertical instance's advance = pix_en && horizontal wrap.

Test Plan:
1. Reset release, CLK_DIV=2 → pix_en toggles every other clock; h_count reaches 1 after 2 clocks; line period exactly 1600 clocks; frame period exactly 840000 clocks.
2. Horizontal sync → during v=0, hsync low exactly for h=656..751 (96 pixels); bright high exactly for h=0..639 (after the first frame); bright low for v=480..524 at all h.
3. Vertical sync and wrap → vsync low exactly for v=490..491 (1600 pixels); the edge from (799,524) yields (0,0); v_count never exceeds 524 and h_count never exceeds 799.
4. frame_tick → exactly one pulse per frame, one clock wide, coincident with h=0, v=480; none in the partial frame before the first v=480.
5. Asynchronous reset mid-operation → drop reset at h=300, v=200 between clock edges: outputs immediately read h=0, v=0, hsync=1, vsync=1, bright=0, pix_en=0; normal timing resumes after release.
6. Parameter override CLK_DIV=1, H_VISIBLE=8, H_FRONT=2, H_SYNC=3, H_BACK=1, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 → line 14 clocks, hsync low h=10..12, vsync low v=5, frame 98 clocks, frame_tick at (0,4).
